// File: rtl/logic8_serial.sv
// logic8_serial: bit-serial bitwise logic unit (AND/OR/XOR/NAND).
// Operands are captured on start, evaluated one bit per clock LSB first,
// and the reassembled word is offered to the consumer with a valid/ready
// handshake.
//
// Handshake: the result is transferred at a rising edge where C_valid and
// C_ready are both high; C_valid stays high and C/Z stay stable until then.
module logic8_serial #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic [WIDTH-1:0] C,
   output logic             Z,
   output logic             C_valid,
   input  logic             C_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       op_q;
   logic             bit_res;
   logic [WIDTH-1:0] r_nxt;
   logic             last_bit;

   // Result bit for the current LSB pair, selected by the captured opcode.
   always_comb begin
      bit_res = 1'b0;
      case (op_q)
         2'b00:   bit_res = a_sh[0] & b_sh[0];
         2'b01:   bit_res = a_sh[0] | b_sh[0];
         2'b10:   bit_res = a_sh[0] ^ b_sh[0];
         default: bit_res = ~(a_sh[0] & b_sh[0]);
      endcase
   end

   // The new bit enters at the MSB, so after WIDTH shifts the LSB-first
   // stream sits in its natural bit positions.
   assign r_nxt    = {bit_res, r_sh[WIDTH-1:1]};
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // Next-state logic for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    if (C_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand capture, serial evaluation and result publication.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         r_sh <= '0;
         cnt  <= '0;
         op_q <= 2'b00;
         C    <= '0;
         Z    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= A;
                  b_sh <= B;
                  op_q <= op;
                  r_sh <= '0;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               r_sh <= r_nxt;
               cnt  <= cnt + CNT_W'(1);
               // C is only written once the full word is assembled.
               if (last_bit) begin
                  C <= r_nxt;
                  Z <= (r_nxt == '0);
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs decode straight from the state register.
   assign busy    = (state != IDLE);
   assign C_valid = (state == DONE);

endmodule

// File: doc/logic8_serial.md
Name: logic8_serial

Overview:
- Multi-cycle, bit-serial bitwise logic unit for the ALU datapath.
- Captures two WIDTH-bit operands and an opcode on a start pulse.
- Evaluates one bit per clock, LSB first, and shifts each result bit into a deserialising result register.
- Presents the reassembled word to the downstream consumer through a valid/ready handshake.
- It is the sequential counterpart to the team's parallel bitwise units; it trades area for latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, 5, width of the internal bit counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  opcode, sampled with start: 00 AND, 01 OR, 10 XOR, 11 NAND.
- A  input  WIDTH  operand A, sampled with start.
- B  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while an operation is accepted and not yet delivered (RUN or DONE).
- C  output  WIDTH  result word; registered.
- Z  output  1  zero flag; high when C == 0; registered and updated together with C.
- C_valid  output  1  result available.
- C_ready  input  1  consumer accepts the result when C_valid and C_ready are both high at a rising edge.

Behaviour:
- Reset: rst_n low asynchronously forces:
  - state IDLE;
  - busy 0, C_valid 0, C all zeros, Z 1;
  - bit counter 0; operand shift registers 0; op register 00.
- Release is synchronous to the clock; the first active edge after rst_n rises may accept start.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load A, B and op into internal shift registers, clear the counter, go to RUN; busy=1 after that edge.
  - start=0: remain in IDLE.
  - C and Z hold the previous result.
- RUN, each edge:
  - compute bit = f(op, a_sh[0], b_sh[0]), where NAND = ~(a&b).
  - shift bit into the MSB of r_sh; shift a_sh and b_sh right by one.
  - increment the counter.
  - on the edge where the counter reaches WIDTH-1: load C <= final r_sh value (including this bit), Z <= (that value == 0), C_valid <= 1, go to DONE.
- Latency: start accepted at edge k gives C_valid=1 after edge k+WIDTH (k+8 for the default). Exactly WIDTH RUN edges.
- DONE:
  - C_valid=1; C and Z stable.
  - When C_valid & C_ready at an edge: C_valid <= 0, busy <= 0, go to IDLE.
  - Otherwise hold indefinitely (backpressure); C must not change.
- start outside IDLE is ignored, including the cycle in which DONE hands off. A start asserted in that cycle is dropped and must be reasserted.
- A, B and op changing after capture have no effect on the operation in flight.
- C_ready while not in DONE is ignored.
- C changes only on the completing RUN edge. It is never partially updated and visible; the shift register is internal.
- Reset asserted mid-RUN or in DONE: the operation is aborted; no C_valid pulse; C returns to 0 and Z to 1.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release, no start for 5 cycles -> C=8'h00, Z=1, busy=0, C_valid=0 throughout.
- AND with latency check: A=8'hF0, B=8'h3C, op=00, one-cycle start at edge k, C_ready=1 -> C_valid high after edge k+8 for one cycle, C=8'h30, Z=0, busy low after edge k+9.
- Opcode sweep: A=8'hA5, B=8'h0F, each op in turn, C_ready=1 -> C = 8'h05, 8'hAF, 8'hAA, 8'hFA respectively. Then A=8'h55, B=8'hAA, op=00 -> C=8'h00, Z=1.
- Backpressure and ignored start: XOR 8'hFF^8'h0F with C_ready=0 for 10 cycles after valid, while start pulses with A=8'h00 -> C_valid and C=8'hF0 held stable, second start ignored. C_ready=1 -> handshake completes, return to IDLE, no second result.
- Operand change mid-run: OR with A=8'h01, B=8'h80; change A/B to 8'hFF at edge k+3 -> C=8'h81.
- Reset mid-operation: start AND 8'hFF&8'hFF, assert rst_n low at edge k+4 -> immediately busy=0, C=8'h00, Z=1, and no C_valid pulse ever. After release, a new OR 8'h12|8'h21 -> C=8'h33 after 8 edges.
